// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection and mult/div occupancy tracking.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   ir_d/e/m   : instructions currently in the D, E and M stages
//   stall_f    : hold PC
//   stall_d    : hold F/D register
//   flush_e    : load a nop into the D/E register
//   md_start   : mult/div start pulse (combinational, md_op in E)
//   md_busy    : mult/div unit still computing (registered)
//   stall_cnt  : saturating count of stall cycles
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] ir_m,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_e,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e   state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [5:0] op_d, op_e, op_m, funct_d, funct_e;
  logic [4:0] rs_d, rt_d, rt_e, rd_e, rt_m;
  logic       rtype_d, rtype_e, load_e, load_m, beq_d;
  logic       md_op_d, md_op_e, hilo_op_d;
  logic       ld_haz, br_haz, md_haz, stall;

  always_comb begin
    op_d    = ir_d[31:26];
    op_e    = ir_e[31:26];
    op_m    = ir_m[31:26];
    rs_d    = ir_d[25:21];
    rt_d    = ir_d[20:16];
    rt_e    = ir_e[20:16];
    rd_e    = ir_e[15:11];
    rt_m    = ir_m[20:16];
    funct_d = ir_d[5:0];
    funct_e = ir_e[5:0];

    rtype_d   = (op_d == OP_RTYPE);
    rtype_e   = (op_e == OP_RTYPE);
    load_e    = (op_e == OP_LOAD);
    load_m    = (op_m == OP_LOAD);
    beq_d     = (op_d == OP_BEQ);
    md_op_d   = rtype_d && (funct_d[5:2] == 4'b0110);
    md_op_e   = rtype_e && (funct_e[5:2] == 4'b0110);
    hilo_op_d = (rtype_d && (funct_d[5:2] == 4'b0100)) || md_op_d;

    // A nop in D reads $0 only, so the rt/rd != 0 guards already
    // exclude it as a consumer; the explicit check just makes that obvious.
    ld_haz = (ir_d != '0) && load_e && (rt_e != '0) &&
             ((rt_e == rs_d) || (rt_e == rt_d));
    br_haz = beq_d &&
             ((rtype_e && (rd_e != '0) && ((rd_e == rs_d) || (rd_e == rt_d))) ||
              (load_m  && (rt_m != '0) && ((rt_m == rs_d) || (rt_m == rt_d))));

    md_start = md_op_e;
    md_busy  = (state_q == BUSY);
    md_haz   = hilo_op_d && (md_start || md_busy);

    stall   = ld_haz | br_haz | md_haz;
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
  end

  // Start reloads the counter even mid-operation; otherwise count down.
  always_comb begin
    count_d = count_q;
    if (md_start)
      count_d = funct_e[1] ? 4'(DIV_LAT) : 4'(MULT_LAT);
    else if (count_q != '0)
      count_d = count_q - 4'd1;
    state_d = (count_d != '0) ? BUSY : IDLE;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d, ir_e, ir_m;
  logic        stall_f, stall_d, flush_e, md_start, md_busy;
  logic [31:0] stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d), .ir_e(ir_e), .ir_m(ir_m),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] LW_8      = 32'h8C08_0000; // lw $8,0($0)
  localparam logic [31:0] LW_2      = 32'h8C02_0000; // lw $2,0($0)
  localparam logic [31:0] LW_0      = 32'h8C00_0000; // lw $0,0($0)
  localparam logic [31:0] ADD_9_88  = 32'h0108_4820; // add $9,$8,$8
  localparam logic [31:0] ADD_9_18  = 32'h0028_4820; // add $9,$1,$8
  localparam logic [31:0] ADD_9_00  = 32'h0000_4820; // add $9,$0,$0
  localparam logic [31:0] ADD_9_20  = 32'h0040_4820; // add $9,$2,$0
  localparam logic [31:0] ADD_1_23  = 32'h0043_0820; // add $1,$2,$3
  localparam logic [31:0] ADD_1_34  = 32'h0064_0820; // add $1,$3,$4
  localparam logic [31:0] ADD_0_34  = 32'h0064_0020; // add $0,$3,$4
  localparam logic [31:0] ADD_3_45  = 32'h0085_1820; // add $3,$4,$5
  localparam logic [31:0] BEQ_1_2   = 32'h1022_0003; // beq $1,$2,3
  localparam logic [31:0] BEQ_0_5   = 32'h1005_0000; // beq $0,$5,0
  localparam logic [31:0] MULT_45   = 32'h0085_0018; // mult $4,$5
  localparam logic [31:0] DIV_45    = 32'h0085_001A; // div $4,$5
  localparam logic [31:0] MFLO_2    = 32'h0000_1012; // mflo $2

  typedef struct {
    logic [31:0] d, e, m;
    logic        stall, start;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_f"}, {31'd0, stall_f}, {31'd0, exp});
    check({name, ".stall_d"}, {31'd0, stall_d}, {31'd0, exp});
    check({name, ".flush_e"}, {31'd0, flush_e}, {31'd0, exp});
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    @(negedge clk);
    ir_d = d; ir_e = e; ir_m = m;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ir_d = NOP; ir_e = NOP; ir_m = NOP;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned busy_cycles;
    int unsigned exp_cnt;

    reset = 1'b1; ir_d = NOP; ir_e = NOP; ir_m = NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.md_busy", {31'd0, md_busy}, 32'd0);
    check("reset.stall_cnt", stall_cnt, 32'd0);
    check_stall("reset", 1'b0);

    // Combinational decode table; md unit idle except for the last two rows.
    vecs[0]  = '{NOP,      NOP,      NOP,  1'b0, 1'b0};
    vecs[1]  = '{ADD_9_88, LW_8,     NOP,  1'b1, 1'b0};
    vecs[2]  = '{ADD_9_18, LW_8,     NOP,  1'b1, 1'b0};
    vecs[3]  = '{ADD_9_00, LW_8,     NOP,  1'b0, 1'b0};
    vecs[4]  = '{ADD_9_00, LW_0,     NOP,  1'b0, 1'b0};
    vecs[5]  = '{BEQ_1_2,  ADD_1_34, NOP,  1'b1, 1'b0};
    vecs[6]  = '{BEQ_1_2,  NOP,      LW_2, 1'b1, 1'b0};
    vecs[7]  = '{BEQ_1_2,  ADD_0_34, NOP,  1'b0, 1'b0};
    vecs[8]  = '{BEQ_0_5,  ADD_0_34, LW_0, 1'b0, 1'b0};
    vecs[9]  = '{ADD_9_20, NOP,      LW_2, 1'b0, 1'b0};
    vecs[10] = '{BEQ_1_2,  ADD_3_45, NOP,  1'b0, 1'b0};
    vecs[11] = '{MFLO_2,   NOP,      NOP,  1'b0, 1'b0};
    vecs[12] = '{NOP,      MULT_45,  NOP,  1'b0, 1'b1};
    vecs[13] = '{MFLO_2,   MULT_45,  NOP,  1'b1, 1'b1};

    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].d, vecs[i].e, vecs[i].m);
      check_stall($sformatf("vec%0d", i), vecs[i].stall);
      check($sformatf("vec%0d.md_start", i), {31'd0, md_start}, {31'd0, vecs[i].start});
      if (vecs[i].stall) exp_cnt++;
    end
    drive(NOP, NOP, NOP);
    check("table.stall_cnt", stall_cnt, exp_cnt);

    // Load-use: exactly one stall cycle, then the bubble resolves it.
    do_reset();
    drive(ADD_9_88, LW_8, NOP);
    check_stall("lu.t", 1'b1);
    drive(ADD_9_88, NOP, LW_8);
    check_stall("lu.t+1", 1'b0);
    check("lu.stall_cnt", stall_cnt, 32'd1);

    // mult then mflo: stall t..t+5, busy t+1..t+5.
    do_reset();
    drive(MFLO_2, MULT_45, NOP);
    check("mul.t.md_start", {31'd0, md_start}, 32'd1);
    check("mul.t.md_busy", {31'd0, md_busy}, 32'd0);
    check_stall("mul.t", 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drive(MFLO_2, NOP, NOP);
      check($sformatf("mul.t+%0d.md_busy", k), {31'd0, md_busy}, (k <= 5) ? 32'd1 : 32'd0);
      check($sformatf("mul.t+%0d.md_start", k), {31'd0, md_start}, 32'd0);
      check_stall($sformatf("mul.t+%0d", k), (k <= 5));
    end
    check("mul.stall_cnt", stall_cnt, 32'd6);

    // div occupancy: busy exactly 10 cycles, independent add never stalls.
    do_reset();
    drive(ADD_1_23, DIV_45, NOP);
    check_stall("div.t", 1'b0);
    busy_cycles = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(ADD_1_23, NOP, NOP);
      if (md_busy) busy_cycles++;
      if (stall_f) busy_cycles = busy_cycles + 100;
    end
    check("div.busy_cycles", busy_cycles, 32'd10);
    check("div.stall_cnt", stall_cnt, 32'd0);

    // Restart mid-operation: div then mult two cycles later reloads to 5.
    do_reset();
    drive(NOP, DIV_45, NOP);
    drive(NOP, NOP, NOP);
    drive(NOP, MULT_45, NOP);
    check("reload.busy_before", {31'd0, md_busy}, 32'd1);
    busy_cycles = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(NOP, NOP, NOP);
      if (md_busy) busy_cycles++;
    end
    check("reload.busy_cycles", busy_cycles, 32'd5);

    // Reset while count = 3 aborts the operation and clears stall_cnt.
    do_reset();
    drive(MFLO_2, MULT_45, NOP);     // t
    drive(MFLO_2, NOP, NOP);         // t+1, count 5
    drive(MFLO_2, NOP, NOP);         // t+2, count 4
    @(negedge clk);                  // t+3, count 3
    reset = 1'b1;
    #1;
    check("rst_mid.busy_before", {31'd0, md_busy}, 32'd1);
    check("rst_mid.cnt_before", stall_cnt, 32'd3);
    check_stall("rst_mid.comb_in_reset", 1'b1);
    @(negedge clk);
    reset = 1'b0; ir_d = NOP;
    #1;
    check("rst_mid.md_busy", {31'd0, md_busy}, 32'd0);
    check("rst_mid.stall_cnt", stall_cnt, 32'd0);

    // Saturation: preload near the top, stall 3 cycles, must stick at max.
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    check("sat.preload", stall_cnt, 32'hFFFF_FFFE);
    for (int k = 1; k <= 3; k++) begin
      drive(ADD_9_88, LW_8, NOP);
      check_stall($sformatf("sat.stall%0d", k), 1'b1);
      @(negedge clk);
      #1;
      check($sformatf("sat.cnt%0d", k), stall_cnt, 32'hFFFF_FFFF);
    end
    drive(NOP, NOP, NOP);
    @(negedge clk);
    #1;
    check("sat.hold", stall_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
